// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: decodes B-type outcome from ALU flags, issues
// a one-cycle redirect, and holds fetch off during the flush window.
module branch_resolve_unit #(
  parameter int N            = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       funct3,
  input  logic             zero_flag,
  input  logic             carry_flag,
  input  logic             overflow_flag,
  input  logic             sign_flag,
  input  logic [N-1:0]     pc,
  input  logic [N-1:0]     imm,
  input  logic             halt_req,
  input  logic             resume,
  output logic             taken,
  output logic [N-1:0]     target,
  output logic             redirect,
  output logic             flush,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FW-1:0] FLOAD = FW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state;
  logic [FW-1:0] fcnt;
  logic        pending;
  logic        dec_taken;
  logic        dec_illegal;
  logic        pend_nxt;
  logic [N-1:0] sum;

  assign br_ready = (state == RUN) && !halt_req;
  assign sum      = pc + imm;
  assign pend_nxt = pending | halt_req;

  always_comb begin
    dec_taken   = 1'b0;
    dec_illegal = 1'b0;
    unique case (1'b1)
      (funct3 == 3'b000): dec_taken = zero_flag;
      (funct3 == 3'b001): dec_taken = !zero_flag;
      (funct3 == 3'b100): dec_taken = sign_flag ^ overflow_flag;
      (funct3 == 3'b101): dec_taken = !(sign_flag ^ overflow_flag);
      (funct3 == 3'b110): dec_taken = !carry_flag;
      (funct3 == 3'b111): dec_taken = carry_flag;
      default:            dec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      fcnt      <= '0;
      pending   <= 1'b0;
      taken     <= 1'b0;
      target    <= '0;
      redirect  <= 1'b0;
      flush     <= 1'b0;
      illegal   <= 1'b0;
      halted    <= 1'b0;
      taken_cnt <= '0;
    end else begin
      redirect <= 1'b0;
      illegal  <= 1'b0;
      unique case (state)
        RUN: begin
          // halt wins over a branch presented in the same cycle
          if (halt_req) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else if (br_valid) begin
            taken   <= dec_taken;
            target  <= {sum[N-1:1], 1'b0};
            illegal <= dec_illegal;
            if (dec_taken) begin
              redirect <= 1'b1;
              flush    <= 1'b1;
              fcnt     <= FLOAD;
              state    <= FLUSH;
              if (taken_cnt != '1)
                taken_cnt <= taken_cnt + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (fcnt == '0) begin
            flush   <= 1'b0;
            pending <= 1'b0;
            if (pend_nxt) begin
              state  <= HALTED;
              halted <= 1'b1;
            end else begin
              state <= RUN;
            end
          end else begin
            fcnt    <= fcnt - 1'b1;
            pending <= pend_nxt;
          end
        end
        HALTED: begin
          if (resume && !halt_req) begin
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= RUN;
          flush  <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: vector table plus
// hand-written flush, halt and reset sequences.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        br_valid;
  logic        br_ready;
  logic [2:0]  funct3;
  logic        zero_flag, carry_flag, overflow_flag, sign_flag;
  logic [31:0] pc, imm;
  logic        halt_req, resume;
  logic        taken;
  logic [31:0] target;
  logic        redirect, flush, illegal, halted;
  logic [1:0]  taken_cnt;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.N(32), .FLUSH_CYCLES(2), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .br_valid(br_valid), .br_ready(br_ready),
    .funct3(funct3),
    .zero_flag(zero_flag), .carry_flag(carry_flag),
    .overflow_flag(overflow_flag), .sign_flag(sign_flag),
    .pc(pc), .imm(imm),
    .halt_req(halt_req), .resume(resume),
    .taken(taken), .target(target),
    .redirect(redirect), .flush(flush),
    .illegal(illegal), .halted(halted),
    .taken_cnt(taken_cnt)
  );

  typedef struct {
    logic [2:0]  f3;
    logic        z, c, v, s;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        tk;
    logic [31:0] tgt;
    logic        ill;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    funct3        = v.f3;
    zero_flag     = v.z;
    carry_flag    = v.c;
    overflow_flag = v.v;
    sign_flag     = v.s;
    pc            = v.pc;
    imm           = v.imm;
  endtask

  task automatic bump();
    if (exp_cnt < 3) exp_cnt++;
  endtask

  task automatic wait_flush(input string nm);
    chk({nm, " flush1"}, 32'(flush), 32'd1);
    chk({nm, " rdy1"}, 32'(br_ready), 32'd0);
    tick();
    chk({nm, " flush2"}, 32'(flush), 32'd1);
    chk({nm, " rdy2"}, 32'(br_ready), 32'd0);
    chk({nm, " redir2"}, 32'(redirect), 32'd0);
    tick();
    chk({nm, " flush_end"}, 32'(flush), 32'd0);
    chk({nm, " rdy_end"}, 32'(br_ready), 32'd1);
  endtask

  task automatic apply(input int i);
    string nm;
    nm = $sformatf("vec%0d", i);
    drive(vecs[i]);
    br_valid = 1'b1;
    #1;
    chk({nm, " ready"}, 32'(br_ready), 32'd1);
    tick();
    br_valid = 1'b0;
    if (vecs[i].tk) bump();
    chk({nm, " taken"}, 32'(taken), 32'(vecs[i].tk));
    chk({nm, " target"}, target, vecs[i].tgt);
    chk({nm, " illegal"}, 32'(illegal), 32'(vecs[i].ill));
    chk({nm, " redirect"}, 32'(redirect), 32'(vecs[i].tk));
    chk({nm, " cnt"}, 32'(taken_cnt), 32'(exp_cnt));
    if (vecs[i].tk) begin
      wait_flush(nm);
    end else begin
      chk({nm, " noflush"}, 32'(flush), 32'd0);
      chk({nm, " rdy"}, 32'(br_ready), 32'd1);
    end
    tick();
    chk({nm, " redir_idle"}, 32'(redirect), 32'd0);
    chk({nm, " ill_idle"}, 32'(illegal), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{3'b000, 1, 0, 0, 0, 32'h100, 32'h20, 1, 32'h120, 0};
    vecs[1]  = '{3'b000, 0, 0, 0, 0, 32'h200, 32'h10, 0, 32'h210, 0};
    vecs[2]  = '{3'b001, 0, 0, 0, 0, 32'h1000, 32'hFFFFFFF0, 1, 32'hFF0, 0};
    vecs[3]  = '{3'b100, 0, 0, 1, 1, 32'h40, 32'h8, 0, 32'h48, 0};
    vecs[4]  = '{3'b100, 0, 0, 0, 1, 32'h80, 32'h4, 1, 32'h84, 0};
    vecs[5]  = '{3'b101, 0, 0, 1, 0, 32'h10, 32'h10, 0, 32'h20, 0};
    vecs[6]  = '{3'b110, 0, 1, 0, 0, 32'h300, 32'h4, 0, 32'h304, 0};
    vecs[7]  = '{3'b111, 0, 1, 0, 0, 32'h304, 32'h8, 1, 32'h30C, 0};
    vecs[8]  = '{3'b010, 1, 0, 0, 0, 32'h500, 32'h4, 0, 32'h504, 1};
    vecs[9]  = '{3'b000, 1, 0, 0, 0, 32'hFFFFFFF0, 32'h21, 1, 32'h10, 0};
    vecs[10] = '{3'b011, 1, 1, 0, 0, 32'h600, 32'h8, 0, 32'h608, 1};
    vecs[11] = '{3'b110, 0, 0, 0, 0, 32'h0, 32'h7FE, 1, 32'h7FE, 0};

    rst_n = 1'b0; br_valid = 1'b0; halt_req = 1'b0; resume = 1'b0;
    funct3 = 3'b0; zero_flag = 0; carry_flag = 0;
    overflow_flag = 0; sign_flag = 0; pc = '0; imm = '0;
    #12;
    chk("rst taken", 32'(taken), 32'd0);
    chk("rst target", target, 32'd0);
    chk("rst redirect", 32'(redirect), 32'd0);
    chk("rst flush", 32'(flush), 32'd0);
    chk("rst halted", 32'(halted), 32'd0);
    chk("rst cnt", 32'(taken_cnt), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst ready", 32'(br_ready), 32'd1);

    for (int i = 0; i < 12; i++) apply(i);

    // back-to-back: BLTU C=1 not taken, then BGEU C=1 taken
    drive(vecs[6]);
    br_valid = 1'b1;
    tick();
    chk("b2b first taken", 32'(taken), 32'd0);
    chk("b2b first ready", 32'(br_ready), 32'd1);
    drive(vecs[7]);
    tick();
    br_valid = 1'b0;
    bump();
    chk("b2b second taken", 32'(taken), 32'd1);
    chk("b2b second redir", 32'(redirect), 32'd1);
    chk("b2b target", target, 32'h30C);
    chk("b2b cnt", 32'(taken_cnt), 32'(exp_cnt));
    wait_flush("b2b");

    // halt requested during flush
    drive(vecs[0]);
    br_valid = 1'b1;
    tick();
    br_valid = 1'b0;
    halt_req = 1'b1;
    chk("hf redirect", 32'(redirect), 32'd1);
    chk("hf halted0", 32'(halted), 32'd0);
    tick();
    chk("hf flush", 32'(flush), 32'd1);
    chk("hf halted1", 32'(halted), 32'd0);
    tick();
    chk("hf halted", 32'(halted), 32'd1);
    chk("hf flush_end", 32'(flush), 32'd0);
    chk("hf rdy", 32'(br_ready), 32'd0);
    resume = 1'b1;
    tick();
    chk("hf both high", 32'(halted), 32'd1);
    halt_req = 1'b0;
    tick();
    resume = 1'b0;
    chk("hf resumed", 32'(halted), 32'd0);
    chk("hf rdy_after", 32'(br_ready), 32'd1);

    // halt_req beats br_valid in RUN
    drive(vecs[4]);
    br_valid = 1'b1;
    halt_req = 1'b1;
    #1;
    chk("hb ready", 32'(br_ready), 32'd0);
    tick();
    br_valid = 1'b0;
    halt_req = 1'b0;
    chk("hb halted", 32'(halted), 32'd1);
    chk("hb redirect", 32'(redirect), 32'd0);
    chk("hb target kept", target, 32'h120);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("hb resumed", 32'(br_ready), 32'd1);

    // reset in the middle of a flush window
    drive(vecs[0]);
    br_valid = 1'b1;
    tick();
    br_valid = 1'b0;
    chk("rf flush", 32'(flush), 32'd1);
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    chk("rf flush0", 32'(flush), 32'd0);
    chk("rf redir0", 32'(redirect), 32'd0);
    chk("rf cnt0", 32'(taken_cnt), 32'd0);
    chk("rf taken0", 32'(taken), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("rf ready", 32'(br_ready), 32'd1);
    chk("rf halted", 32'(halted), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
